// File: rtl/isa_pkg.sv
// Shared widths, constants and the fetch-queue entry type for the instruction fetch path.
package isa_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0]  PC_STEP          = 32'h0000_0004;
   localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;
   localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [ADDR_W-1:0]  ALIGN_MASK       = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Shift-register FIFO of {pc,instr}: slot 0 is always the head, so the head output is a
// plain register. Synchronous flush empties the queue and overrides push.
module fetch_queue
   import isa_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [ADDR_W-1:0]  i_pc,
   input  logic [INSTR_W-1:0] i_instr,
   output logic               o_valid,
   output logic [ADDR_W-1:0]  o_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic [CW-1:0]      o_count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t r_q [DEPTH];
   fetch_entry_t w_next_q [DEPTH];
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_next_count;
   logic [CW-1:0] w_rem;
   logic          r_valid;

   // Next queue contents: shift toward the head on pop, write behind the survivors on push.
   always_comb begin
      w_next_q     = r_q;
      w_next_count = r_count;
      w_rem        = r_count - (i_pop ? CW'(1) : CW'(0));
      if (i_flush) begin
         w_next_count = '0;
      end else begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (i_pop && ((i + 1) < int'(r_count))) begin
               w_next_q[i] = r_q[i+1];
            end else begin
               w_next_q[i] = w_next_q[i];
            end
         end
         if (i_push) begin
            w_next_q[w_rem[AW-1:0]] = '{pc: i_pc, instr: i_instr};
            w_next_count            = w_rem + CW'(1);
         end else begin
            w_next_count = w_rem;
         end
      end
   end

   // Queue storage, occupancy and registered valid flag.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_q     <= '{default: '{pc: '0, instr: NOP}};
         r_count <= '0;
         r_valid <= 1'b0;
      end else begin
         r_q     <= w_next_q;
         r_count <= w_next_count;
         r_valid <= (w_next_count != CW'(0));
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_q[0].pc;
   assign o_instr = r_q[0].instr;
   assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: owns the PC, fetches one word per cycle into the fetch queue and
// presents the queue head to decode; a redirect flushes the queue and reloads the PC.
module instruction_fetch_unit
   import isa_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int                QUEUE_DEPTH = 2
) (
   input  logic                         Clk,
   input  logic                         Reset,
   output logic [ADDR_W-1:0]            ImemAddress,
   input  logic [INSTR_W-1:0]           ImemInstruction,
   input  logic                         Halt,
   input  logic                         Redirect,
   input  logic [ADDR_W-1:0]            RedirectTarget,
   output logic                         InstrValid,
   output logic [INSTR_W-1:0]           InstrOut,
   output logic [ADDR_W-1:0]            InstrPC,
   input  logic                         InstrReady,
   output logic [$clog2(QUEUE_DEPTH):0] QueueCount
);

   localparam int CW = $clog2(QUEUE_DEPTH) + 1;

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_next_pc;
   logic              w_pop;
   logic              w_full;
   logic              w_push;

   assign w_pop  = InstrValid & InstrReady;
   assign w_full = (QueueCount == CW'(QUEUE_DEPTH));
   // A pop frees a slot in the same edge, so a full queue still accepts a fetch.
   assign w_push = ~Halt & ~Redirect & (~w_full | w_pop);

   // PC update: redirect wins, otherwise advance only when the fetched word is enqueued.
   always_comb begin
      w_next_pc = r_pc;
      if (Redirect) begin
         w_next_pc = align_pc(RedirectTarget);
      end else if (w_push) begin
         w_next_pc = r_pc + PC_STEP;
      end else begin
         w_next_pc = r_pc;
      end
   end

   // PC register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   assign ImemAddress = r_pc;

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .CW    (CW)
   ) u_queue (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_flush (Redirect),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_pc    (r_pc),
      .i_instr (ImemInstruction),
      .o_valid (InstrValid),
      .o_pc    (InstrPC),
      .o_instr (InstrOut),
      .o_count (QueueCount)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: default instance plus a RESET_PC=FFFF_FFFC
// instance for PC wrap; memory holds mem[i] = i*3.
module tb_instruction_fetch_unit;

   logic        Clk;
   logic        Reset;
   logic [31:0] ImemAddress;
   logic [31:0] ImemInstruction;
   logic        Halt;
   logic        Redirect;
   logic [31:0] RedirectTarget;
   logic        InstrValid;
   logic [31:0] InstrOut;
   logic [31:0] InstrPC;
   logic        InstrReady;
   logic [1:0]  QueueCount;

   logic        Reset_w;
   logic [31:0] ImemAddress_w;
   logic [31:0] ImemInstruction_w;
   logic        Halt_w;
   logic        Redirect_w;
   logic [31:0] RedirectTarget_w;
   logic        InstrValid_w;
   logic [31:0] InstrOut_w;
   logic [31:0] InstrPC_w;
   logic        InstrReady_w;
   logic [1:0]  QueueCount_w;

   logic [31:0] mem [128];
   int          n_cmp = 0;
   int          n_err = 0;
   logic        mon_en = 1'b0;
   int          cnt_10 = 0;
   int          cnt_14 = 0;

   assign ImemInstruction   = mem[ImemAddress[8:2]];
   assign ImemInstruction_w = mem[ImemAddress_w[8:2]];

   instruction_fetch_unit dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .ImemAddress     (ImemAddress),
      .ImemInstruction (ImemInstruction),
      .Halt            (Halt),
      .Redirect        (Redirect),
      .RedirectTarget  (RedirectTarget),
      .InstrValid      (InstrValid),
      .InstrOut        (InstrOut),
      .InstrPC         (InstrPC),
      .InstrReady      (InstrReady),
      .QueueCount      (QueueCount)
   );

   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .Clk             (Clk),
      .Reset           (Reset_w),
      .ImemAddress     (ImemAddress_w),
      .ImemInstruction (ImemInstruction_w),
      .Halt            (Halt_w),
      .Redirect        (Redirect_w),
      .RedirectTarget  (RedirectTarget_w),
      .InstrValid      (InstrValid_w),
      .InstrOut        (InstrOut_w),
      .InstrPC         (InstrPC_w),
      .InstrReady      (InstrReady_w),
      .QueueCount      (QueueCount_w)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Counts handshakes of PC 0x10 / 0x14; sampled half a cycle before the accepting edge.
   always @(negedge Clk) begin
      if (mon_en && InstrValid && InstrReady) begin
         if (InstrPC == 32'h0000_0010) cnt_10 <= cnt_10 + 1;
         if (InstrPC == 32'h0000_0014) cnt_14 <= cnt_14 + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      #2;
      chk("rst_valid", {31'd0, InstrValid}, 32'd0);
      chk("rst_count", {30'd0, QueueCount}, 32'd0);
      chk("rst_addr", ImemAddress, 32'h0000_0000);
      Reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = i * 3;
      Reset = 1'b0; Halt = 1'b0; Redirect = 1'b0; RedirectTarget = 32'd0; InstrReady = 1'b1;
      Reset_w = 1'b0; Halt_w = 1'b0; Redirect_w = 1'b0; RedirectTarget_w = 32'd0;
      InstrReady_w = 1'b1;
      #2;
      chk("init_out", InstrOut, 32'd0);
      chk("init_pc", InstrPC, 32'd0);
      chk("init_valid", {31'd0, InstrValid}, 32'd0);
      chk("init_count", {30'd0, QueueCount}, 32'd0);
      chk("init_addr", ImemAddress, 32'd0);
      #2;

      // 1: free run from reset
      tick();
      Reset = 1'b1;
      chk("t1_valid_pre", {31'd0, InstrValid}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t1_valid", {31'd0, InstrValid}, 32'd1);
         chk("t1_pc", InstrPC, 32'(k * 4));
         chk("t1_out", InstrOut, 32'(k * 3));
      end

      // 2: decode stalled, queue fills, then drains with no gap
      InstrReady = 1'b0;
      do_reset();
      tick();
      chk("t2_count1", {30'd0, QueueCount}, 32'd1);
      chk("t2_addr1", ImemAddress, 32'h4);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t2_count", {30'd0, QueueCount}, 32'd2);
         chk("t2_addr", ImemAddress, 32'h8);
         chk("t2_head", InstrPC, 32'h0);
      end
      InstrReady = 1'b1;
      tick();
      chk("t2_pc4", InstrPC, 32'h4);
      chk("t2_out4", InstrOut, 32'd3);
      chk("t2_cnt4", {30'd0, QueueCount}, 32'd2);
      tick();
      chk("t2_pc8", InstrPC, 32'h8);
      chk("t2_out8", InstrOut, 32'd6);
      chk("t2_valid8", {31'd0, InstrValid}, 32'd1);

      // 3: redirect while full
      InstrReady = 1'b0;
      do_reset();
      tick(); tick(); tick();
      chk("t3_full", {30'd0, QueueCount}, 32'd2);
      Redirect = 1'b1; RedirectTarget = 32'h0000_0043;
      tick();
      chk("t3_valid0", {31'd0, InstrValid}, 32'd0);
      chk("t3_count0", {30'd0, QueueCount}, 32'd0);
      chk("t3_addr", ImemAddress, 32'h40);
      Redirect = 1'b0; InstrReady = 1'b1;
      tick();
      chk("t3_valid", {31'd0, InstrValid}, 32'd1);
      chk("t3_pc", InstrPC, 32'h40);
      chk("t3_out", InstrOut, 32'd48);

      // 4: redirect in the same cycle as the pop of PC 0x10
      do_reset();
      mon_en = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      chk("t4_head10", InstrPC, 32'h10);
      Redirect = 1'b1; RedirectTarget = 32'h0000_0100;
      tick();
      chk("t4_valid0", {31'd0, InstrValid}, 32'd0);
      chk("t4_addr", ImemAddress, 32'h100);
      Redirect = 1'b0;
      tick();
      chk("t4_pc", InstrPC, 32'h100);
      chk("t4_out", InstrOut, 32'd192);
      tick(); tick(); tick();
      mon_en = 1'b0;
      chk("t4_cnt10", 32'(cnt_10), 32'd1);
      chk("t4_cnt14", 32'(cnt_14), 32'd0);

      // 5: halt drains the queue and freezes the PC
      InstrReady = 1'b0;
      do_reset();
      tick(); tick();
      chk("t5_count2", {30'd0, QueueCount}, 32'd2);
      Halt = 1'b1; InstrReady = 1'b1;
      tick();
      chk("t5_count1", {30'd0, QueueCount}, 32'd1);
      chk("t5_pc4", InstrPC, 32'h4);
      chk("t5_addr1", ImemAddress, 32'h8);
      tick();
      chk("t5_valid0", {31'd0, InstrValid}, 32'd0);
      chk("t5_count0", {30'd0, QueueCount}, 32'd0);
      tick();
      chk("t5_addr_hold", ImemAddress, 32'h8);
      chk("t5_still_empty", {31'd0, InstrValid}, 32'd0);
      Halt = 1'b0;
      tick();
      chk("t5_resume_valid", {31'd0, InstrValid}, 32'd1);
      chk("t5_resume_pc", InstrPC, 32'h8);
      chk("t5_resume_out", InstrOut, 32'd6);
      chk("t5_resume_addr", ImemAddress, 32'hC);

      // 6: PC wrap and mid-stream reset on the FFFF_FFFC instance
      chk("t6_rst_addr", ImemAddress_w, 32'hFFFF_FFFC);
      Reset_w = 1'b1;
      tick();
      chk("t6_pc_top", InstrPC_w, 32'hFFFF_FFFC);
      chk("t6_out_top", InstrOut_w, 32'd381);
      chk("t6_addr_wrap", ImemAddress_w, 32'h0);
      tick();
      chk("t6_pc_wrap", InstrPC_w, 32'h0);
      chk("t6_out_wrap", InstrOut_w, 32'd0);
      tick();
      chk("t6_pc_4", InstrPC_w, 32'h4);
      Reset_w = 1'b0;
      #1;
      chk("t6_mid_valid", {31'd0, InstrValid_w}, 32'd0);
      chk("t6_mid_out", InstrOut_w, 32'd0);
      chk("t6_mid_pc", InstrPC_w, 32'd0);
      chk("t6_mid_count", {30'd0, QueueCount_w}, 32'd0);
      chk("t6_mid_addr", ImemAddress_w, 32'hFFFF_FFFC);
      Reset_w = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
